// File: rtl/wb_commit_if.sv
// Bundle between the MEM/WB register/consumers and the write-back commit stage.
// The master drives the wb_* bundle and read requests; the slave is the commit block.
interface wb_commit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic [ADDR_W-1:0] i_wb_wd;
  logic              i_wb_wreg;
  logic [DATA_W-1:0] i_wb_wdata;
  logic [DATA_W-1:0] i_wb_hi;
  logic [DATA_W-1:0] i_wb_lo;
  logic              i_wb_whilo;
  logic              i_wb_LLbit_we;
  logic              i_wb_LLbit_value;
  logic              i_flush;
  logic              i_re1;
  logic              i_re2;
  logic [ADDR_W-1:0] i_raddr1;
  logic [ADDR_W-1:0] i_raddr2;
  logic [DATA_W-1:0] o_rdata1;
  logic [DATA_W-1:0] o_rdata2;
  logic [DATA_W-1:0] o_hi;
  logic [DATA_W-1:0] o_lo;
  logic              o_LLbit;
  logic [CNT_W-1:0]  o_commit_cnt;

  modport master (
    output i_wb_wd, i_wb_wreg, i_wb_wdata, i_wb_hi, i_wb_lo, i_wb_whilo,
           i_wb_LLbit_we, i_wb_LLbit_value, i_flush, i_re1, i_re2, i_raddr1, i_raddr2,
    input  o_rdata1, o_rdata2, o_hi, o_lo, o_LLbit, o_commit_cnt
  );

  modport slave (
    input  i_wb_wd, i_wb_wreg, i_wb_wdata, i_wb_hi, i_wb_lo, i_wb_whilo,
           i_wb_LLbit_we, i_wb_LLbit_value, i_flush, i_re1, i_re2, i_raddr1, i_raddr2,
    output o_rdata1, o_rdata2, o_hi, o_lo, o_LLbit, o_commit_cnt
  );
endinterface

// File: rtl/wb_commit.sv
// Write-back commit stage: GPR file with same-cycle bypass, HI/LO pair, LLbit and
// a committed-GPR-write counter.
module wb_commit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_commit_if.slave  bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_gpr [NREGS];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_llbit;
  logic [CNT_W-1:0]  r_commitCnt;
  logic              w_gprWe;

  // Register 0 is never written, so it keeps its reset value and is masked on read anyway.
  assign w_gprWe = bus.i_wb_wreg && (bus.i_wb_wd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
    end else if (w_gprWe) begin
      r_gpr[bus.i_wb_wd] <= bus.i_wb_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (bus.i_wb_whilo) begin
      r_hi <= bus.i_wb_hi;
      r_lo <= bus.i_wb_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.i_flush) r_llbit <= 1'b0;
    else if (bus.i_wb_LLbit_we) r_llbit <= bus.i_wb_LLbit_value;
  end

  always_ff @(posedge clk) begin
    if (rst) r_commitCnt <= '0;
    else if (w_gprWe) r_commitCnt <= r_commitCnt + 1'b1;
  end

  function automatic logic [DATA_W-1:0] readPort(input logic re, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    data = '0;
    if (!rst && re && (addr != '0)) begin
      if (bus.i_wb_wreg && (bus.i_wb_wd == addr)) data = bus.i_wb_wdata;
      else data = r_gpr[addr];
    end
    return data;
  endfunction

  // Both ports see the in-flight write-back value so ID never stalls on a WB hazard.
  always_comb begin
    bus.o_rdata1 = readPort(bus.i_re1, bus.i_raddr1);
    bus.o_rdata2 = readPort(bus.i_re2, bus.i_raddr2);
  end

  always_comb begin
    bus.o_LLbit = r_llbit;
    if (rst || bus.i_flush) bus.o_LLbit = 1'b0;
    else if (bus.i_wb_LLbit_we) bus.o_LLbit = bus.i_wb_LLbit_value;
  end

  assign bus.o_hi         = r_hi;
  assign bus.o_lo         = r_lo;
  assign bus.o_commit_cnt = r_commitCnt;
endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: a driver predicts each cycle's outputs from an
// architectural model and queues them; a monitor compares what the DUT presents.
module tb_wb_commit;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  // A narrow counter lets the wrap from all-ones back to zero be reached quickly.
  localparam int CNT_W  = 8;

  typedef struct {
    logic              rst;
    logic              wreg;
    logic [ADDR_W-1:0] wd;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              llwe;
    logic              llval;
    logic              flush;
    logic              re1;
    logic [ADDR_W-1:0] ra1;
    logic              re2;
    logic [ADDR_W-1:0] ra2;
  } stim_t;

  typedef struct {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              ll;
    logic [CNT_W-1:0]  cnt;
    bit                chkRegs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_commit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  wb_commit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Architectural model
  logic [DATA_W-1:0] mRegs [32];
  logic [DATA_W-1:0] mHi, mLo;
  logic              mLl;
  logic [CNT_W-1:0]  mCnt;
  bit                mKnown = 0;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  function automatic void checkOutput(input string name, input logic [DATA_W-1:0] act,
                                      input logic [DATA_W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DATA_W-1:0] modelRead(input stim_t s, input logic re,
                                                  input logic [ADDR_W-1:0] a);
    if (s.rst || !re || a == 0) return '0;
    if (s.wreg && s.wd == a) return s.wdata;
    return mRegs[a];
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst                  = s.rst;
    bus.i_wb_wreg        = s.wreg;
    bus.i_wb_wd          = s.wd;
    bus.i_wb_wdata       = s.wdata;
    bus.i_wb_whilo       = s.whilo;
    bus.i_wb_hi          = s.hi;
    bus.i_wb_lo          = s.lo;
    bus.i_wb_LLbit_we    = s.llwe;
    bus.i_wb_LLbit_value = s.llval;
    bus.i_flush          = s.flush;
    bus.i_re1            = s.re1;
    bus.i_raddr1         = s.ra1;
    bus.i_re2            = s.re2;
    bus.i_raddr2         = s.ra2;
    e.rd1     = modelRead(s, s.re1, s.ra1);
    e.rd2     = modelRead(s, s.re2, s.ra2);
    e.hi      = mHi;
    e.lo      = mLo;
    e.ll      = (s.rst || s.flush) ? 1'b0 : (s.llwe ? s.llval : mLl);
    e.cnt     = mCnt;
    e.chkRegs = mKnown;
    expQ.push_back(e);
    // Architectural effect of the coming clock edge
    if (s.rst) begin
      for (int i = 0; i < 32; i++) mRegs[i] = '0;
      mHi = '0; mLo = '0; mLl = 1'b0; mCnt = '0; mKnown = 1;
    end else begin
      if (s.wreg && s.wd != 0) begin
        mRegs[s.wd] = s.wdata;
        mCnt = mCnt + 1'b1;
      end
      if (s.whilo) begin
        mHi = s.hi; mLo = s.lo;
      end
      if (s.flush) mLl = 1'b0;
      else if (s.llwe) mLl = s.llval;
    end
  endtask

  // Monitor: combinational outputs settle well before the next rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("rdata1", bus.o_rdata1, e.rd1);
        checkOutput("rdata2", bus.o_rdata2, e.rd2);
        checkOutput("LLbit_o", {31'b0, bus.o_LLbit}, {31'b0, e.ll});
        if (e.chkRegs) begin
          checkOutput("hi_o", bus.o_hi, e.hi);
          checkOutput("lo_o", bus.o_lo, e.lo);
          checkOutput("commit_cnt", {24'b0, bus.o_commit_cnt}, {24'b0, e.cnt});
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    waitCycles;
    rst = 1'b1;
    bus.i_wb_wreg = 0; bus.i_wb_wd = 0; bus.i_wb_wdata = 0; bus.i_wb_whilo = 0;
    bus.i_wb_hi = 0; bus.i_wb_lo = 0; bus.i_wb_LLbit_we = 0; bus.i_wb_LLbit_value = 0;
    bus.i_flush = 0; bus.i_re1 = 0; bus.i_raddr1 = 0; bus.i_re2 = 0; bus.i_raddr2 = 0;

    // Reset for two cycles, with junk writes that must be dropped
    s = idle(); s.rst = 1; s.wreg = 1; s.wd = 7; s.wdata = 32'h1111_2222; s.re1 = 1; s.ra1 = 7;
    s.llwe = 1; s.llval = 1; s.whilo = 1; s.hi = 32'h5; s.lo = 32'h6;
    applyStimulus(s);
    applyStimulus(s);
    for (int i = 1; i < 32; i++) begin
      s = idle(); s.re1 = 1; s.ra1 = ADDR_W'(i); s.re2 = 1; s.ra2 = ADDR_W'(32 - i);
      applyStimulus(s);
    end

    // Bypass then committed value
    s = idle(); s.wreg = 1; s.wd = 5; s.wdata = 32'hDEAD_BEEF; s.re1 = 1; s.ra1 = 5;
    applyStimulus(s);
    s = idle(); s.re1 = 1; s.ra1 = 5;
    applyStimulus(s);

    // Write to r0 discarded
    s = idle(); s.wreg = 1; s.wd = 0; s.wdata = 32'h1234; s.re1 = 1; s.ra1 = 0;
    applyStimulus(s);
    s.wreg = 0;
    applyStimulus(s);

    // Read enable low masks data; HI/LO visible one cycle later
    s = idle(); s.re2 = 0; s.ra2 = 5; s.re1 = 1; s.ra1 = 5;
    applyStimulus(s);
    s = idle(); s.whilo = 1; s.hi = 32'hAAAA_0000; s.lo = 32'h0000_BBBB;
    applyStimulus(s);
    applyStimulus(idle());

    // LLbit bypass, hold, and flush priority
    s = idle(); s.llwe = 1; s.llval = 1;
    applyStimulus(s);
    applyStimulus(idle());
    s = idle(); s.flush = 1; s.llwe = 1; s.llval = 1;
    applyStimulus(s);
    applyStimulus(idle());

    // Counter wrap: reset, reach all-ones, then one more write to r3
    s = idle(); s.rst = 1;
    applyStimulus(s);
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      s = idle(); s.wreg = 1; s.wd = ADDR_W'($urandom_range(1, 31)); s.wdata = $urandom;
      applyStimulus(s);
    end
    s = idle(); s.wreg = 1; s.wd = 3; s.wdata = 32'hCAFE_F00D; s.re1 = 1; s.ra1 = 3;
    applyStimulus(s);
    s = idle(); s.re1 = 1; s.ra1 = 3;
    applyStimulus(s);

    // Randomized traffic concentrated on few registers to provoke bypass hits
    for (int i = 0; i < 2000; i++) begin
      s.rst   = ($urandom_range(0, 63) == 0);
      s.wreg  = $urandom_range(0, 1);
      s.wd    = ADDR_W'($urandom_range(0, 7));
      s.wdata = $urandom;
      s.whilo = ($urandom_range(0, 3) == 0);
      s.hi    = $urandom;
      s.lo    = $urandom;
      s.llwe  = ($urandom_range(0, 3) == 0);
      s.llval = $urandom_range(0, 1);
      s.flush = ($urandom_range(0, 7) == 0);
      s.re1   = ($urandom_range(0, 7) != 0);
      s.ra1   = ADDR_W'($urandom_range(0, 7));
      s.re2   = ($urandom_range(0, 7) != 0);
      s.ra2   = ($urandom_range(0, 3) == 0) ? s.ra1 : ADDR_W'($urandom_range(0, 31));
      applyStimulus(s);
    end

    applyStimulus(idle());
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    #3;
    if (expQ.size() > 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain: %0d entries left expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
